capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 178 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer
//  Description : Arms, triggers and records a fixed-length ADC capture into a
//                storage FIFO, then drains it to the serial transmitter.
//                Optional build macro CAPTURE_AUTOTRIGGER_EN adds a timer that
//                self-triggers after TIMEOUT cycles spent in ARMED.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Arm,
  input  logic             Abort,
  input  logic             Trigger,
  input  logic [CNT_W-1:0] RecordLength,
  input  logic             FifoNotFull,
  input  logic             FifoNotEmpty,
  input  logic             TxBusy,
  output logic             WriteStrobe,
  output logic             FifoReset,
  output logic             DrainEnable,
  output logic [1:0]       State,
  output logic             Done,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DRAIN  = 2'd3
  } stateT;

  stateT            r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_writeStrobe;
  logic             r_fifoReset;
  logic             r_drainEnable;
  logic             r_done;
  logic             r_overflow;

  stateT            w_nextState;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_nextWriteStrobe;
  logic             w_nextFifoReset;
  logic             w_nextDrainEnable;
  logic             w_nextDone;
  logic             w_nextOverflow;
  logic             w_fire;

`ifdef CAPTURE_AUTOTRIGGER_EN
  localparam int c_timerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [c_timerW-1:0] r_timer;
  logic                w_timeout;

  // Timer never exceeds TIMEOUT-1: reaching it fires and leaves ARMED.
  assign w_timeout = (r_timer == c_timerW'(TIMEOUT - 1));
  assign w_fire    = Trigger || w_timeout;

  // Count cycles spent in ARMED; cleared whenever ARMED is entered or left.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_timer <= '0;
    end else if (r_state == ARMED && w_nextState == ARMED) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end
`else
  assign w_fire = Trigger;

  // TIMEOUT only shapes the auto-trigger timer; this keeps one parameter set
  // for both builds without building anything here.
  if (TIMEOUT < 1) begin : g_timeoutUnused
  end
`endif

  // Next-state and next-output decode. Every output is launched from a flop,
  // so FifoNotFull is judged at the edge that would launch the next strobe.
  always_comb begin
    w_nextState       = r_state;
    w_nextCount       = r_count;
    w_nextWriteStrobe = 1'b0;
    w_nextFifoReset   = 1'b0;
    w_nextDrainEnable = 1'b0;
    w_nextDone        = 1'b0;
    w_nextOverflow    = r_overflow;

    if (Abort) begin
      // Abort beats everything, including a coincident Arm in IDLE.
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (Arm) begin
            w_nextState     = ARMED;
            w_nextFifoReset = 1'b1;
            w_nextOverflow  = 1'b0;
          end
        end
        ARMED: begin
          if (w_fire) begin
            if (RecordLength == '0) begin
              w_nextState       = DRAIN;
              w_nextDrainEnable = 1'b1;
            end else begin
              w_nextState       = RECORD;
              w_nextCount       = RecordLength;
              w_nextWriteStrobe = 1'b1;
            end
          end
        end
        RECORD: begin
          // The strobe active this cycle consumes one count.
          w_nextCount = r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            w_nextState       = DRAIN;
            w_nextDrainEnable = 1'b1;
          end else if (!FifoNotFull) begin
            w_nextState       = DRAIN;
            w_nextDrainEnable = 1'b1;
            w_nextOverflow    = 1'b1;
          end else begin
            w_nextWriteStrobe = 1'b1;
          end
        end
        DRAIN: begin
          if (!FifoNotEmpty && !TxBusy) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end else begin
            w_nextDrainEnable = 1'b1;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_writeStrobe <= 1'b0;
      r_fifoReset   <= 1'b0;
      r_drainEnable <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_count       <= w_nextCount;
      r_writeStrobe <= w_nextWriteStrobe;
      r_fifoReset   <= w_nextFifoReset;
      r_drainEnable <= w_nextDrainEnable;
      r_done        <= w_nextDone;
      r_overflow    <= w_nextOverflow;
    end
  end

  assign State       = r_state;
  assign WriteStrobe = r_writeStrobe;
  assign FifoReset   = r_fifoReset;
  assign DrainEnable = r_drainEnable;
  assign Done        = r_done;
  assign Overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_capture_sequencer
//  Description : Self-checking bench for capture_sequencer. Each capture is
//                described by a few numbers (length, trigger delay, FIFO-full
//                point, abort point, drain timing) and the expected strobe
//                count, flags and Done timing are computed from those.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Arm;
  logic             Abort;
  logic             Trigger;
  logic [CNT_W-1:0] RecordLength;
  logic             FifoNotFull;
  logic             FifoNotEmpty;
  logic             TxBusy;
  logic             WriteStrobe;
  logic             FifoReset;
  logic             DrainEnable;
  logic [1:0]       State;
  logic             Done;
  logic             Overflow;

  int total = 0;
  int bad   = 0;
  int strobeTotal = 0;
  int doneTotal   = 0;
  logic expOverflow = 1'b0;

  capture_sequencer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Arm         (Arm),
    .Abort       (Abort),
    .Trigger     (Trigger),
    .RecordLength(RecordLength),
    .FifoNotFull (FifoNotFull),
    .FifoNotEmpty(FifoNotEmpty),
    .TxBusy      (TxBusy),
    .WriteStrobe (WriteStrobe),
    .FifoReset   (FifoReset),
    .DrainEnable (DrainEnable),
    .State       (State),
    .Done        (Done),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;

  // Running tallies of strobe and Done cycles, taken mid-cycle.
  always @(negedge Clock) begin
    strobeTotal += int'(WriteStrobe);
    doneTotal   += int'(Done);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1ns after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One full capture. fullAt=k (k>=2) holds FifoNotFull low from strobe k-1
  // onward, so strobe k cannot be launched. abortAt=k pulses Abort during
  // strobe k. drainAbort pulses Abort in the first DRAIN cycle.
  task automatic runCapture(input int len, input int trigDelay, input int fullAt,
                            input int abortAt, input int emptyLen, input int txTail,
                            input bit drainAbort);
    int  s0;
    int  d0;
    int  cur;
    int  guard;
    int  expStrobes;
    bit  aborted;

    Arm = 1'b1;
    step();
    Arm = 1'b0;
    expOverflow = 1'b0;
    check("arm.state", State, 1);
    check("arm.fifoReset", FifoReset, 1);
    check("arm.overflowClear", Overflow, expOverflow);
    for (int i = 0; i < trigDelay; i++) begin
      step();
      check("armed.hold", State, 1);
      check("armed.fifoResetOnce", FifoReset, 0);
    end

    s0 = strobeTotal;
    Trigger      = 1'b1;
    RecordLength = CNT_W'(len);
    step();
    Trigger      = 1'b0;
    RecordLength = CNT_W'($urandom_range(0, 255));
    check("trig.fifoReset", FifoReset, 0);
    check("trig.state", State, (len == 0) ? 3 : 2);
    check("trig.strobe", WriteStrobe, (len == 0) ? 0 : 1);

    aborted = 1'b0;
    guard   = 0;
    while (State == 2'd2 && !aborted && guard < len + 4) begin
      cur = strobeTotal - s0 + int'(WriteStrobe);
      if (abortAt != 0 && cur == abortAt) begin
        Abort = 1'b1;
        step();
        Abort   = 1'b0;
        aborted = 1'b1;
      end else begin
        FifoNotFull = !(fullAt != 0 && cur >= fullAt - 1);
        step();
      end
      guard++;
    end
    FifoNotFull = 1'b1;

    if (aborted)                             expStrobes = abortAt;
    else if (fullAt >= 2 && fullAt <= len)   expStrobes = fullAt - 1;
    else                                     expStrobes = len;
    expOverflow = !aborted && fullAt >= 2 && fullAt <= len;

    check("record.exitState", State, aborted ? 0 : 3);
    check("record.strobeCount", strobeTotal - s0, expStrobes);
    check("record.strobeOff", WriteStrobe, 0);
    check("record.overflow", Overflow, expOverflow);
    check("record.drainEnable", DrainEnable, aborted ? 0 : 1);

    d0 = doneTotal;
    if (aborted || drainAbort) begin
      if (drainAbort && !aborted) begin
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("drainAbort.state", State, 0);
        check("drainAbort.drainOff", DrainEnable, 0);
        check("drainAbort.overflowKept", Overflow, expOverflow);
      end
      step();
      step();
      check("abort.idle", State, 0);
      check("abort.noDone", doneTotal - d0, 0);
      return;
    end

    for (int i = 0; i <= emptyLen + txTail; i++) begin
      check("drain.enable", DrainEnable, 1);
      check("drain.noEarlyDone", Done, 0);
      FifoNotEmpty = (i < emptyLen);
      TxBusy       = (i < emptyLen + txTail);
      step();
    end
    check("drain.done", Done, 1);
    check("drain.idle", State, 0);
    check("drain.enableOff", DrainEnable, 0);
    check("drain.overflowHeld", Overflow, expOverflow);
    step();
    check("drain.donePulse", Done, 0);
    check("drain.doneCount", doneTotal - d0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int mode;
    int fullAt;
    int abortAt;
    int d0;
    int n;

    Reset        = 1'b1;
    Arm          = 1'b1;
    Abort        = 1'b0;
    Trigger      = 1'b1;
    RecordLength = '0;
    FifoNotFull  = 1'b1;
    FifoNotEmpty = 1'b0;
    TxBusy       = 1'b0;
    step();
    step();
    check("reset.outputs", {State, WriteStrobe, FifoReset, DrainEnable, Done, Overflow}, 0);
    Arm     = 1'b0;
    Trigger = 1'b0;
    Reset   = 1'b0;
    step();
    check("reset.idle", State, 0);

    // Basic capture: trigger after 5 cycles, 8 strobes.
    runCapture(8, 5, 0, 0, 2, 1, 1'b0);
    // Drain held up by the transmitter for 10 cycles after the FIFO empties.
    runCapture(4, 0, 0, 0, 3, 10, 1'b0);
    // FIFO fills at the 6th strobe of 20; the following Arm clears Overflow.
    runCapture(20, 1, 6, 0, 1, 0, 1'b0);
    // Overflow survives an abort during DRAIN.
    runCapture(10, 0, 4, 0, 0, 0, 1'b1);
    // Abort after 3 strobes.
    runCapture(10, 2, 0, 3, 0, 0, 1'b0);
    // Zero-length record goes straight to DRAIN.
    runCapture(0, 1, 0, 0, 1, 1, 1'b0);
    // Full asserted only during the final strobe: no overflow.
    runCapture(3, 0, 4, 0, 0, 0, 1'b0);

    // Arm together with Abort in IDLE is ignored.
    Arm   = 1'b1;
    Abort = 1'b1;
    step();
    Arm   = 1'b0;
    Abort = 1'b0;
    check("armAbort.state", State, 0);
    check("armAbort.noFifoReset", FifoReset, 0);

    // Arm in ARMED is ignored; Abort returns to IDLE.
    Arm = 1'b1;
    step();
    step();
    Arm = 1'b0;
    check("rearm.state", State, 1);
    check("rearm.noFifoReset", FifoReset, 0);
`ifdef CAPTURE_AUTOTRIGGER_EN
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    // Self-trigger after TIMEOUT ARMED cycles.
    RecordLength = CNT_W'(3);
    Arm = 1'b1;
    step();
    Arm = 1'b0;
    n = 0;
    while (State == 2'd1 && n < 4 * TIMEOUT) begin
      n++;
      step();
    end
    check("auto.armedCycles", n, TIMEOUT);
    check("auto.state", State, 2);
    check("auto.strobe", WriteStrobe, 1);
`else
    for (int i = 0; i < 40; i++) step();
    check("armed.waitsForever", State, 1);
`endif
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("abortArmed.state", State, 0);

    // Reset in the middle of RECORD.
    Arm = 1'b1;
    step();
    Arm          = 1'b0;
    RecordLength = CNT_W'(10);
    Trigger      = 1'b1;
    step();
    Trigger = 1'b0;
    step();
    step();
    check("midReset.recording", WriteStrobe, 1);
    d0    = doneTotal;
    Reset = 1'b1;
    step();
    check("midReset.outputs", {State, WriteStrobe, FifoReset, DrainEnable, Done, Overflow}, 0);
    Reset = 1'b0;
    step();
    step();
    check("midReset.idle", State, 0);
    check("midReset.noDone", doneTotal - d0, 0);

    // Randomised captures.
    for (int k = 0; k < 25; k++) begin
      len     = $urandom_range(0, 12);
      mode    = $urandom_range(0, 2);
      fullAt  = 0;
      abortAt = 0;
      if (mode == 1 && len >= 2) fullAt  = $urandom_range(2, len + 1);
      if (mode == 2 && len >= 1) abortAt = $urandom_range(1, len);
      runCapture(len, $urandom_range(0, 4), fullAt, abortAt,
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
